sram_rr_arbiter: RTL

- Two-requester round-robin arbiter and access sequencer in front of the single-port SRAM block.
- Accepts one command at a time from either requester and drives the SRAM wr/rd/addr/wdata strobes for exactly one cycle.
- For reads, captures the SRAM's registered rdata and returns it to the owning requester.
- Rejects out-of-range addresses without touching the SRAM.

---
 rtl/sram_rr_arbiter_if.sv | 44 ++++
 rtl/sram_rr_arbiter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/sram_rr_arbiter_if.sv
// Requester, response and SRAM-side signals of the two-port round-robin SRAM arbiter.
// The slave modport is the arbiter's view; master is the view of the requesters plus the SRAM.
interface sram_rr_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
);
  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;

  logic              gnt0;
  logic              gnt1;
  logic              rvalid0;
  logic              rvalid1;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;
  logic              err0;
  logic              err1;

  logic              sram_wr;
  logic              sram_rd;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_wdata;
  logic [DATA_W-1:0] sram_rdata;

  logic              busy;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, sram_rdata,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, err0, err1,
    output sram_wr, sram_rd, sram_addr, sram_wdata, busy
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, sram_rdata,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, err0, err1,
    input  sram_wr, sram_rd, sram_addr, sram_wdata, busy
  );
endinterface

// File: rtl/sram_rr_arbiter.sv
// Two-requester round-robin arbiter sequencing one command at a time onto a single-port SRAM.
// Every output is a flop; out-of-range addresses are answered with err and never reach the SRAM.
module sram_rr_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 6
) (
  input logic              clk,
  input logic              rst,
  sram_rr_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  state_t            state_q, state_d;
  logic              prio_q, prio_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic              bad_q, bad_d;

  logic              gnt0_q, gnt0_d;
  logic              gnt1_q, gnt1_d;
  logic              err0_q, err0_d;
  logic              err1_q, err1_d;
  logic              rvalid0_q, rvalid0_d;
  logic              rvalid1_q, rvalid1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic              sram_wr_q, sram_wr_d;
  logic              sram_rd_q, sram_rd_d;
  logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
  logic [DATA_W-1:0] sram_wdata_q, sram_wdata_d;
  logic              busy_q, busy_d;

  logic              win;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_bad;

  // prio_q names the favoured requester on a tie; it always points away from the last winner.
  always_comb begin
    win = 1'b0;
    if (bus.req0 && bus.req1) begin
      win = prio_q;
    end else if (bus.req1) begin
      win = 1'b1;
    end
    sel_we    = win ? bus.we1    : bus.we0;
    sel_addr  = win ? bus.addr1  : bus.addr0;
    sel_wdata = win ? bus.wdata1 : bus.wdata0;
    sel_bad   = ({1'b0, sel_addr} >= DEPTH_EXT);
  end

  always_comb begin
    state_d      = state_q;
    prio_d       = prio_q;
    owner_d      = owner_q;
    we_d         = we_q;
    bad_d        = bad_q;
    gnt0_d       = 1'b0;
    gnt1_d       = 1'b0;
    err0_d       = 1'b0;
    err1_d       = 1'b0;
    rvalid0_d    = 1'b0;
    rvalid1_d    = 1'b0;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    sram_wr_d    = 1'b0;
    sram_rd_d    = 1'b0;
    sram_addr_d  = '0;
    sram_wdata_d = '0;

    unique case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          state_d = ACCESS;
          owner_d = win;
          we_d    = sel_we;
          bad_d   = sel_bad;
          prio_d  = ~win;
          gnt0_d  = ~win;
          gnt1_d  = win;
          err0_d  = ~win & sel_bad;
          err1_d  = win & sel_bad;
          if (!sel_bad) begin
            sram_wr_d    = sel_we;
            sram_rd_d    = ~sel_we;
            sram_addr_d  = sel_addr;
            sram_wdata_d = sel_we ? sel_wdata : '0;
          end
        end
      end
      ACCESS: begin
        state_d = we_q ? IDLE : RESP;
      end
      RESP: begin
        // The SRAM's registered read data is valid during this cycle.
        state_d = IDLE;
        if (owner_q) begin
          rvalid1_d = 1'b1;
          rdata1_d  = bad_q ? '0 : bus.sram_rdata;
        end else begin
          rvalid0_d = 1'b1;
          rdata0_d  = bad_q ? '0 : bus.sram_rdata;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      prio_q       <= 1'b0;
      owner_q      <= 1'b0;
      we_q         <= 1'b0;
      bad_q        <= 1'b0;
      gnt0_q       <= 1'b0;
      gnt1_q       <= 1'b0;
      err0_q       <= 1'b0;
      err1_q       <= 1'b0;
      rvalid0_q    <= 1'b0;
      rvalid1_q    <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
      sram_wr_q    <= 1'b0;
      sram_rd_q    <= 1'b0;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      prio_q       <= prio_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      bad_q        <= bad_d;
      gnt0_q       <= gnt0_d;
      gnt1_q       <= gnt1_d;
      err0_q       <= err0_d;
      err1_q       <= err1_d;
      rvalid0_q    <= rvalid0_d;
      rvalid1_q    <= rvalid1_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
      sram_wr_q    <= sram_wr_d;
      sram_rd_q    <= sram_rd_d;
      sram_addr_q  <= sram_addr_d;
      sram_wdata_q <= sram_wdata_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.gnt0       = gnt0_q;
  assign bus.gnt1       = gnt1_q;
  assign bus.err0       = err0_q;
  assign bus.err1       = err1_q;
  assign bus.rvalid0    = rvalid0_q;
  assign bus.rvalid1    = rvalid1_q;
  assign bus.rdata0     = rdata0_q;
  assign bus.rdata1     = rdata1_q;
  assign bus.sram_wr    = sram_wr_q;
  assign bus.sram_rd    = sram_rd_q;
  assign bus.sram_addr  = sram_addr_q;
  assign bus.sram_wdata = sram_wdata_q;
  assign bus.busy       = busy_q;

  // Mutual exclusion of the one-hot pulses.
  assert property (@(posedge clk) disable iff (rst) !(sram_wr_q && sram_rd_q));
  assert property (@(posedge clk) disable iff (rst) !(gnt0_q && gnt1_q));
  assert property (@(posedge clk) disable iff (rst) !(rvalid0_q && rvalid1_q));

endmodule
